// File: rtl/fifo_rr_scheduler.sv
// Round-robin scheduler that drains several upstream FIFOs into one
// valid/ready stream, serving at most max_burst words per grant.
module fifo_rr_scheduler #(
  parameter int n_queues  = 4,
  parameter int width     = 8,
  parameter int max_burst = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [n_queues-1:0]           empty,
  input  logic [n_queues*width-1:0]     read_data,
  output logic [n_queues-1:0]           pop,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [width-1:0]              out_data,
  output logic [$clog2(n_queues)-1:0]   grant_id,
  output logic                          busy
);

  // state | meaning
  // IDLE  | no grant held; pick the next non-empty queue cyclically
  // SERVE | forward words from grant_q until drained or burst exhausted

  localparam int GW = $clog2(n_queues);
  localparam int BW = $clog2(max_burst + 1);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [GW-1:0] pick;

  // Cyclic search starting just after the previous grant; the previous
  // grant itself is examined last, so a lone busy queue is re-granted.
  function automatic logic [GW-1:0] rr_pick(input logic [n_queues-1:0] emp,
                                            input logic [GW-1:0]       last);
    logic [GW-1:0] sel;
    logic          found;
    int            idx;
    sel   = last;
    found = 1'b0;
    for (int k = 1; k <= n_queues; k++) begin
      idx = (int'(last) + k) % n_queues;
      if (!found && !emp[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
    return sel;
  endfunction

  assign pick     = rr_pick(empty, last_q);
  assign grant_id = grant_q;
  assign busy     = (state_q == SERVE);
  assign out_data = read_data[int'(grant_q)*width +: width];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(n_queues - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    burst_d   = burst_q;
    out_valid = 1'b0;
    pop       = '0;
    case (state_q)
      IDLE: begin
        if (!(&empty)) begin
          grant_d = pick;
          last_d  = pick;
          burst_d = '0;
          state_d = SERVE;
        end
      end
      SERVE: begin
        out_valid = !empty[grant_q];
        if (empty[grant_q]) begin
          state_d = IDLE;
        end else if (out_ready) begin
          pop[grant_q] = 1'b1;
          burst_d      = burst_q + BW'(1);
          if (burst_q == BW'(max_burst - 1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Bench for fifo_rr_scheduler: upstream FIFOs and the expected scheduling
// behaviour are modelled with queues and per-grant bookkeeping.
module tb_fifo_rr_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   empty;
  logic [N*W-1:0] read_data;
  logic [N-1:0]   pop;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [1:0]     grant_id;
  logic           busy;

  fifo_rr_scheduler #(.n_queues(N), .width(W), .max_burst(MB)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .read_data(read_data),
    .pop(pop), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] fq[N][$];
  int  m_g;      // queue currently being served, -1 when no grant is held
  int  m_gid;    // last granted queue as shown on grant_id
  int  m_last;
  int  m_n;      // words served in the current grant
  int  pops_q[N];
  int  dut_log[$];
  int  exp_log[$];
  logic prev_busy;
  bit  push_en;
  int  vectors;
  int  miscompares;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit anyq();
    for (int i = 0; i < N; i++) if (fq[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      empty[i] = (fq[i].size() == 0);
      read_data[i*W +: W] = (fq[i].size() > 0) ? fq[i][0] : W'($urandom);
    end
  endtask

  task automatic load(input int q, input int cnt);
    for (int k = 0; k < cnt; k++) fq[q].push_back(W'($urandom));
  endtask

  task automatic check_cycle();
    logic         e_busy, e_valid;
    logic [N-1:0] e_pop;
    e_busy  = (m_g >= 0);
    e_valid = e_busy && (fq[m_g].size() > 0);
    e_pop   = '0;
    if (e_valid && out_ready) e_pop[m_g] = 1'b1;
    chk("busy", busy, e_busy);
    chk("out_valid", out_valid, e_valid);
    chk("pop", pop, e_pop);
    chk("grant_id", grant_id, m_gid);
    if (e_valid) chk("out_data", out_data, fq[m_g][0]);
    if (busy === 1'b1 && prev_busy !== 1'b1) dut_log.push_back(int'(grant_id));
    prev_busy = busy;
  endtask

  task automatic model_edge();
    if (m_g < 0) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (m_g < 0 && fq[idx].size() > 0) begin
          m_g = idx; m_gid = idx; m_last = idx; m_n = 0;
        end
      end
    end else if (fq[m_g].size() == 0) begin
      m_g = -1;
    end else if (out_ready) begin
      void'(fq[m_g].pop_front());
      pops_q[m_g]++;
      m_n++;
      if (m_n == MB) m_g = -1;
    end
  endtask

  task automatic step(input logic rdy);
    out_ready = rdy;
    drive();
    #1;
    check_cycle();
    model_edge();
    if (push_en)
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0 && fq[i].size() < 16) load(i, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((m_g >= 0 || anyq()) && b < 400) begin
      step(1'b1);
      b++;
    end
    step(1'b1);
    chk("drain_bound", (b < 400), 1);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_count"}, dut_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++)
      chk({tag, "_grant"}, dut_log[i], exp_log[i]);
    dut_log.delete();
    exp_log.delete();
  endtask

  task automatic model_reset();
    m_g = -1; m_gid = 0; m_last = N - 1; m_n = 0;
    prev_busy = 1'b0;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_pop", pop, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    model_reset();
    dut_log.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    vectors = 0; miscompares = 0; push_en = 1'b0;
    for (int i = 0; i < N; i++) pops_q[i] = 0;
    model_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) load(i, 10);
    drive();
    #2;
    chk("init_pop", pop, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_busy", busy, 0);
    chk("init_grant_id", grant_id, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // rotation with full bursts, first grant from queue 0
    drain();
    for (int r = 0; r < 3; r++) for (int i = 0; i < N; i++) exp_log.push_back(i);
    check_log("rotation");
    for (int i = 0; i < N; i++) chk("rotation_pops", pops_q[i], 10);

    // fairness: last grant was 3, q0 and q3 pending
    load(0, 2); load(3, 2);
    drain();
    exp_log.push_back(0); exp_log.push_back(3);
    check_log("fairness");

    // single queue
    pops_q[2] = 0;
    load(2, 3);
    drain();
    exp_log.push_back(2);
    check_log("single_q2");
    chk("single_q2_pops", pops_q[2], 3);

    // backpressure after the second word of a burst
    pops_q[1] = 0;
    load(1, 4);
    begin
      int b;
      b = 0;
      while (pops_q[1] < 2 && b < 20) begin step(1'b1); b++; end
      chk("bp_reach_bound", (b < 20), 1);
    end
    for (int k = 0; k < 5; k++) step(1'b0);
    chk("bp_stalled_pops", pops_q[1], 2);
    drain();
    chk("bp_total_pops", pops_q[1], 4);
    exp_log.push_back(1);
    check_log("backpressure");

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < N; i++) load(i, 5);
    step(1'b1); step(1'b1); step(1'b1);
    async_reset();
    drain();
    chk("post_reset_log_nonempty", (dut_log.size() > 0), 1);
    if (dut_log.size() > 0) chk("post_reset_first_grant", dut_log[0], 0);
    dut_log.delete();

    // random traffic and backpressure
    push_en = 1'b1;
    for (int c = 0; c < 1500; c++) step($urandom_range(0, 3) != 0);
    push_en = 1'b0;
    drain();
    dut_log.delete();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 Parameter n_queues, default 4, number of upstream FIFOs served; SHALL be >= 2.
REQ-002 Parameter width, default 8, data word width in bits.
REQ-003 Parameter max_burst, default 4, max consecutive transfers from one queue per grant; SHALL be >= 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 empty  input  n_queues  per-queue empty flag from upstream FIFOs (registered flags, bit i = queue i).
REQ-007 read_data  input  n_queues*width  concatenated FIFO head words; queue i occupies bits [i*width +: width].
REQ-008 pop  output  n_queues  per-queue pop strobe, at most one bit high.
REQ-009 out_valid  output  1  downstream word valid.
REQ-010 out_ready  input  1  downstream accepts word.
REQ-011 out_data  output  width  downstream word.
REQ-012 grant_id  output  $clog2(n_queues)  index of currently granted queue.
REQ-013 busy  output  1  high while in SERVE state.

Function
REQ-014 Two-state FSM SHALL be used: IDLE, SERVE.
REQ-015 IDLE: if any empty bit is low, SHALL select the first non-empty queue searching cyclically from last_grant+1, register it into grant_id and last_grant, clear burst_cnt, go to SERVE; else stay in IDLE.
REQ-016 Arbitration latency SHALL be one cycle: non-empty seen in IDLE at edge t -> out_valid may be high in cycle after t.
REQ-017 SERVE: out_valid SHALL equal !empty[grant_id], combinationally.
REQ-018 out_data SHALL equal read_data slice of grant_id at all times (value irrelevant when out_valid low).
REQ-019 pop[grant_id] SHALL be high iff state is SERVE and out_valid and out_ready; all other pop bits low.
REQ-020 Each transfer (out_valid and out_ready) SHALL increment burst_cnt; width $clog2(max_burst+1), no wrap.
REQ-021 SERVE -> IDLE when a transfer occurs with burst_cnt == max_burst-1 (burst exhausted).
REQ-022 SERVE -> IDLE when empty[grant_id] is high (queue drained); no pop that cycle.
REQ-023 With out_valid high and out_ready low, grant_id, out_data, burst_cnt SHALL hold; out_valid SHALL stay high (no valid withdrawal).
REQ-024 Every grant release SHALL insert exactly one IDLE cycle before the next grant (avoids acting on stale empty flags).
REQ-025 If only the just-released queue is non-empty, the cyclic search SHALL re-grant it.
REQ-026 busy SHALL be high iff state is SERVE.
REQ-027 Block SHALL never pop a queue whose empty flag is high.

Reset
REQ-028 rst_n low SHALL immediately force: state IDLE, grant_id 0, last_grant n_queues-1, burst_cnt 0, pop 0, out_valid 0, busy 0.
REQ-029 Reset mid-burst SHALL abort the grant with no further pops; first grant after release SHALL search from queue 0.

Verification
REQ-030 Reset: rst_n=0 with all queues non-empty -> pop=0, out_valid=0, busy=0, grant_id=0; release -> next grant is queue 0.
REQ-031 Single queue: only q2 holds 3 words, out_ready=1 -> 1 IDLE cycle, grant_id=2, 3 consecutive pops on pop[2], then IDLE when empty[2] rises.
REQ-032 Burst and rotation: all 4 queues hold 10 words, max_burst=4, out_ready=1 -> grants 0,1,2,3,0,... with 4 pops each and one IDLE cycle between grants.
REQ-033 Backpressure: out_ready=0 for 5 cycles after 2nd word of a burst -> out_valid=1, out_data stable, pop=0; resume -> remaining 2 words then release.
REQ-034 Fairness: last grant 3, only q0 and q3 non-empty -> next grant q0, then q3.
REQ-035 Async reset during SERVE mid-cycle -> pop and out_valid drop to 0 before next clock edge.
